// File: rtl/skid_register.sv
// Two-entry elastic pipeline register: an output register plus one skid word, so a
// downstream stall never loses or duplicates data and the ready path stays registered.
module skid_register #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Flush,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             EntradaValida,
  output logic             EntradaPronta,
  output logic [WIDTH-1:0] Saida,
  output logic             SaidaValida,
  input  logic             SaidaPronta,
  output logic [1:0]       Ocupacao
);

  // Encoding equals the number of held words, so occupancy is the state itself.
  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    UM    = 2'd1,
    CHEIO = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] saida_q, saida_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept, take;

  assign SaidaValida   = (state_q != VAZIO);
  assign EntradaPronta = (state_q != CHEIO);
  assign Saida         = saida_q;
  assign Ocupacao      = state_q;

  assign accept = EntradaValida & EntradaPronta;
  assign take   = SaidaValida & SaidaPronta;

  always_comb begin
    // NOTE: every next-state value gets its hold default first, so no path infers a latch.
    state_d = state_q;
    saida_d = saida_q;
    skid_d  = skid_q;

    unique case (state_q)
      VAZIO: begin
        if (accept) begin
          state_d = UM;
          saida_d = Entrada;
        end
      end
      UM: begin
        if (accept && take) begin
          saida_d = Entrada;
        end else if (accept) begin
          state_d = CHEIO;
          skid_d  = Entrada;
        end else if (take) begin
          state_d = VAZIO;
        end
      end
      CHEIO: begin
        if (take) begin
          state_d = UM;
          saida_d = skid_q;
        end
      end
      default: state_d = VAZIO;
    endcase

    // Flush wins over any same-cycle accept or take; the data registers keep their values.
    if (Flush) begin
      state_d = VAZIO;
      saida_d = saida_q;
      skid_d  = skid_q;
    end
  end

  // NOTE: both data registers are reset too, because Saida must read 0 out of reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= VAZIO;
      saida_q <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      saida_q <= saida_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_register.sv
// Self-checking bench for skid_register: a queue-based FIFO model checked every
// negative edge, plus directed scenarios with hand-computed expectations.
module tb_skid_register;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Flush = 1'b0;
  logic [W-1:0] Entrada = '0;
  logic         EntradaValida = 1'b0;
  logic         EntradaPronta;
  logic [W-1:0] Saida;
  logic         SaidaValida;
  logic         SaidaPronta = 1'b0;
  logic [1:0]   Ocupacao;

  int n_cmp = 0;
  int n_err = 0;
  bit armed = 1'b0;

  skid_register #(.WIDTH(W)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Flush(Flush),
    .Entrada(Entrada),
    .EntradaValida(EntradaValida),
    .EntradaPronta(EntradaPronta),
    .Saida(Saida),
    .SaidaValida(SaidaValida),
    .SaidaPronta(SaidaPronta),
    .Ocupacao(Ocupacao)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a capacity-2 FIFO; Saida shows the head, or the last head once empty.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mq.delete();
      m_last = '0;
    end else begin
      automatic bit acc = EntradaValida && (mq.size() < 2);
      automatic bit tk  = SaidaPronta && (mq.size() > 0);
      if (Flush) begin
        mq.delete();
      end else begin
        if (tk) void'(mq.pop_front());
        if (acc) mq.push_back(Entrada);
      end
      if (mq.size() > 0) m_last = mq[0];
    end
  end

  always @(negedge Clk) begin
    if (armed) begin
      check("model_saida", Saida, m_last);
      check("model_valid", W'(SaidaValida), W'(mq.size() > 0));
      check("model_ready", W'(EntradaPronta), W'(mq.size() < 2));
      check("model_occ", W'(Ocupacao), W'(mq.size()));
    end
  end

  task automatic step(input logic ev, input logic [W-1:0] d, input logic sp, input logic fl);
    EntradaValida = ev;
    Entrada       = d;
    SaidaPronta   = sp;
    Flush         = fl;
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] s, input logic v,
                            input logic r, input logic [1:0] occ);
    check({name, "_saida"}, Saida, s);
    check({name, "_valid"}, W'(SaidaValida), W'(v));
    check({name, "_ready"}, W'(EntradaPronta), W'(r));
    check({name, "_occ"}, W'(Ocupacao), W'(occ));
  endtask

  initial begin
    #50;
    Rst = 1'b1;
    #1;
    armed = 1'b1;
    expect_out("reset_during", 0, 0, 1, 0);
    #149;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    expect_out("reset_after", 0, 0, 1, 0);

    // Streaming with the consumer always ready.
    step(1, 15, 1, 0); expect_out("stream15", 15, 1, 1, 1);
    step(1, 16, 1, 0); expect_out("stream16", 16, 1, 1, 1);
    step(1, 17, 1, 0); expect_out("stream17", 17, 1, 1, 1);
    step(1, 18, 1, 0); expect_out("stream18", 18, 1, 1, 1);
    step(0, 0, 1, 0);  expect_out("stream_end", 18, 0, 1, 0);

    // Stall: second word goes to skid, third is held off.
    step(1, 15, 0, 0); expect_out("stall1", 15, 1, 1, 1);
    step(1, 20, 0, 0); expect_out("stall2", 15, 1, 0, 2);
    step(1, 25, 0, 0); expect_out("stall3", 15, 1, 0, 2);
    step(1, 25, 1, 0); expect_out("release1", 20, 1, 1, 1);
    step(1, 25, 1, 0); expect_out("release2", 25, 1, 1, 1);
    step(0, 0, 1, 0);  expect_out("release3", 25, 0, 1, 0);

    // Drain a full register with no new input.
    step(1, 15, 0, 0);
    step(1, 20, 0, 0); expect_out("drain_full", 15, 1, 0, 2);
    step(0, 0, 1, 0);  expect_out("drain1", 20, 1, 1, 1);
    step(0, 0, 1, 0);  expect_out("drain2", 20, 0, 1, 0);

    // Flush while full, with a competing accept of 99.
    step(1, 30, 0, 0);
    step(1, 40, 0, 0); expect_out("flush_full", 30, 1, 0, 2);
    step(1, 99, 0, 1); expect_out("flush", 30, 0, 1, 0);
    step(0, 0, 0, 0);  expect_out("flush_after", 30, 0, 1, 0);

    // Flush beats a simultaneous accept and take in UM.
    step(1, 50, 0, 0); expect_out("flush_um_pre", 50, 1, 1, 1);
    step(1, 51, 1, 1); expect_out("flush_um", 50, 0, 1, 0);

    // Asynchronous reset while full, then one word after release.
    step(1, 60, 0, 0);
    step(1, 61, 0, 0); expect_out("rst_full", 60, 1, 0, 2);
    #2;
    Rst = 1'b1;
    #1;
    expect_out("rst_mid", 0, 0, 1, 0);
    @(negedge Clk);
    @(negedge Clk);
    #1;
    Rst = 1'b0;
    step(1, 7, 1, 0); expect_out("post_rst7", 7, 1, 1, 1);
    step(0, 0, 1, 0); expect_out("post_rst_end", 7, 0, 1, 0);

    @(negedge Clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
